// File: rtl/wb_sram_streamer.sv
// Pipelined Wishbone read master that fetches a block of SRAM words and
// streams them out through a small FIFO with valid/ready and a last marker.
module wb_sram_streamer #(
  parameter int ABITS  = 10,
  parameter int LBITS  = 10,
  parameter int FDEPTH = 4,
  parameter int DELAY  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [ABITS-1:0] base_i,
  input  logic [LBITS-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic             m_bst_o,
  output logic [ABITS-1:0] m_adr_o,
  input  logic             m_ack_i,
  input  logic [31:0]      m_dat_i,
  output logic             s_valid_o,
  input  logic             s_ready_i,
  output logic [31:0]      s_data_o,
  output logic             s_last_o
);
  localparam int PBITS = $clog2(FDEPTH);
  localparam logic [LBITS:0] FDEPTH_L = (LBITS+1)'(FDEPTH);

  // DELAY only exists so older instantiations keep elaborating; no delay is modelled.
  if (FDEPTH < 2 || (FDEPTH & (FDEPTH - 1)) != 0 || DELAY < 0) begin : g_param_check
    $error("wb_sram_streamer: FDEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;
  state_t state;

  logic [ABITS-1:0] base_q;
  logic [LBITS-1:0] len_q, issued, acked, popped;
  logic [31:0]      mem [FDEPTH];
  logic [PBITS-1:0] wr_ptr, rd_ptr;
  logic [PBITS:0]   count;
  logic [LBITS:0]   outstanding, credit;
  logic             ack_ok, pop, flush;

  // Credit counts words in flight on the bus plus words parked in the FIFO.
  assign outstanding = {1'b0, issued - acked};
  assign credit      = outstanding + (LBITS+1)'(count);

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign m_cyc_o   = (state == READ) || (state == WAIT && acked != len_q);
  assign m_stb_o   = (state == READ) && (issued < len_q) && (credit < FDEPTH_L);
  assign m_we_o    = 1'b0;
  assign m_bst_o   = m_stb_o && ((len_q - issued) > LBITS'(1));
  assign m_adr_o   = base_q + ABITS'(issued);
  assign s_valid_o = (count != '0);
  assign s_data_o  = s_valid_o ? mem[rd_ptr] : '0;
  assign s_last_o  = s_valid_o && (popped == len_q - LBITS'(1));

  assign ack_ok = m_ack_i && m_cyc_o && (issued != acked);
  assign pop    = s_valid_o && s_ready_i;
  assign flush  = abort_i && (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (ack_ok) mem[wr_ptr] <= m_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      acked  <= '0;
      popped <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (ack_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
          acked  <= acked + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          popped <= popped + 1'b1;
        end
        if (ack_ok && !pop)      count <= count + 1'b1;
        else if (!ack_ok && pop) count <= count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            base_q <= base_i;
            len_q  <= len_i;
            issued <= '0;
            acked  <= '0;
            popped <= '0;
            state  <= (len_i == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (abort_i) state <= IDLE;
          else if (m_stb_o) begin
            issued <= issued + 1'b1;
            if (issued == len_q - LBITS'(1)) state <= WAIT;
          end
        end
        WAIT: begin
          if (abort_i) state <= IDLE;
          else if (acked == len_q && count == '0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
